// File: rtl/inst_pkg.sv
// Shared encodings and instruction field layout for the pipelined executor.
// Instruction layout, MSB first: {op[1:0], rd, alu_op[2:0], rs1, rs2}.
package inst_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOADI = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  function automatic int inst_width(input int reg_aw);
    return 2 + 3 * reg_aw + 3;
  endfunction

  function automatic int op_lsb(input int reg_aw);
    return 3 * reg_aw + 3;
  endfunction

  function automatic int rd_lsb(input int reg_aw);
    return 2 * reg_aw + 3;
  endfunction

  function automatic int aluop_lsb(input int reg_aw);
    return 2 * reg_aw;
  endfunction

  function automatic int rs1_lsb(input int reg_aw);
    return reg_aw;
  endfunction

endpackage

// File: rtl/inst_alu.sv
// Combinational ALU: eight operations, signed-overflow flag for ADD/SUB only.
module inst_alu
  import inst_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_op,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [SH_W-1:0]   w_shamt;

  assign w_sum   = a + b;
  assign w_diff  = a - b;
  assign w_shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result = w_sum;
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result = w_diff;
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (w_diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << w_shamt;
      ALU_SRL: result = a >> w_shamt;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_exec_pipe.sv
// Two-stage instruction executor: S1 holds the instruction, S2 the result.
// The register file is written on the S1->S2 edge, so dependent instructions never stall.
module inst_exec_pipe
  import inst_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int REG_AW = 5,
  parameter  int CNT_W  = 16,
  localparam int INST_W = inst_width(REG_AW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] instruccion,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALU_Result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int NREG   = 2 ** REG_AW;
  localparam int IMM_W  = 2 * REG_AW;
  localparam int OP_L   = op_lsb(REG_AW);
  localparam int RD_L   = rd_lsb(REG_AW);
  localparam int AOP_L  = aluop_lsb(REG_AW);
  localparam int RS1_L  = rs1_lsb(REG_AW);

  logic              r_s1_valid;
  logic [INST_W-1:0] r_s1_inst;
  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic [REG_AW-1:0] r_rd;
  logic              r_zero;
  logic              r_ovf;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_retired;
  logic [CNT_W-1:0]  r_illegal_cnt;

  logic [1:0]        w_op;
  logic [REG_AW-1:0] w_rd;
  logic [2:0]        w_alu_op;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_rs1_val;
  logic [DATA_W-1:0] w_rs2_val;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_ovf;
  logic [DATA_W-1:0] w_result;
  logic              w_ovf;
  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_s1_load;
  logic              w_wr_en;
  logic              w_hand;

  assign w_op     = r_s1_inst[OP_L +: 2];
  assign w_rd     = r_s1_inst[RD_L +: REG_AW];
  assign w_alu_op = r_s1_inst[AOP_L +: 3];
  assign w_rs1    = r_s1_inst[RS1_L +: REG_AW];
  assign w_rs2    = r_s1_inst[REG_AW-1:0];
  assign w_imm    = r_s1_inst[IMM_W-1:0];

  assign w_rs1_val = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

  inst_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (w_rs1_val),
    .b      (w_rs2_val),
    .alu_op (w_alu_op),
    .result (w_alu_res),
    .ovf    (w_alu_ovf)
  );

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (w_op)
      OP_ALU: begin
        w_result = w_alu_res;
        w_ovf    = w_alu_ovf;
      end
      OP_LOADI: w_result = DATA_W'(w_imm);
      default: ;
    endcase
  end

  assign w_s2_adv  = !r_out_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_adv;
  assign in_ready  = !rst && (!r_s1_valid || w_s2_adv);
  assign w_s1_load = in_valid && in_ready;
  assign w_hand    = r_out_valid && out_ready;
  // Writeback is tied to the S1->S2 move, so a stalled S2 also blocks the write.
  assign w_wr_en   = w_s1_adv && ((w_op == OP_ALU) || (w_op == OP_LOADI)) && (w_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_rd] <= w_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_inst     <= '0;
      r_out_valid   <= 1'b0;
      r_result      <= '0;
      r_rd          <= '0;
      r_zero        <= 1'b0;
      r_ovf         <= 1'b0;
      r_illegal     <= 1'b0;
      r_retired     <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
        r_s1_inst  <= instruccion;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result  <= w_result;
          r_rd      <= w_rd;
          r_zero    <= (w_result == '0);
          r_ovf     <= w_ovf;
          r_illegal <= (w_op == OP_ILL);
        end
      end
      if (w_hand) begin
        if (r_retired != {CNT_W{1'b1}}) r_retired <= r_retired + CNT_W'(1);
        if (r_illegal && (r_illegal_cnt != {CNT_W{1'b1}}))
          r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign ALU_Result  = r_result;
  assign out_rd      = r_rd;
  assign out_zero    = r_zero;
  assign out_ovf     = r_ovf;
  assign out_illegal = r_illegal;
  assign retired_cnt = r_retired;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_inst_exec_pipe.sv
// Directed and random checks of inst_exec_pipe against an in-order reference model.
module tb_inst_exec_pipe;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        zero;
    logic        ovf;
    logic        ill;
    int          acc_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] instruccion;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALU_Result;
  logic [4:0]  out_rd;
  logic        out_zero;
  logic        out_ovf;
  logic        out_illegal;
  logic [15:0] retired_cnt;
  logic [15:0] illegal_cnt;

  inst_exec_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruccion (instruccion),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALU_Result  (ALU_Result),
    .out_rd      (out_rd),
    .out_zero    (out_zero),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal),
    .retired_cnt (retired_cnt),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] mregs [32];
  exp_t        exp_q [$];
  logic [31:0] obs_res [$];
  logic        obs_zero [$];
  logic        obs_ovf [$];
  logic        obs_ill [$];
  int          model_ret = 0;
  int          model_ill = 0;
  bit          chk_lat = 1'b1;
  bit          rnd_rdy = 1'b0;
  bit          acc_flag;
  bit          held = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [19:0] mk(input int op, input int rd, input int aop,
                                     input int rs1, input int rs2);
    return {op[1:0], rd[4:0], aop[2:0], rs1[4:0], rs2[4:0]};
  endfunction

  // Reference: executes in program order on an array of register values.
  task automatic model_exec(input logic [19:0] ins, output exp_t e);
    logic [31:0] a, b, res;
    longint      s;
    a = (ins[9:5] == 0) ? 32'd0 : mregs[ins[9:5]];
    b = (ins[4:0] == 0) ? 32'd0 : mregs[ins[4:0]];
    res = 32'd0;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    case (ins[19:18])
      2'd1: begin
        case (ins[12:10])
          3'd0: begin
            s = longint'($signed(a)) + longint'($signed(b));
            res = a + b;
            e.ovf = (s != longint'($signed(res)));
          end
          3'd1: begin
            s = longint'($signed(a)) - longint'($signed(b));
            res = a - b;
            e.ovf = (s != longint'($signed(res)));
          end
          3'd2: res = a & b;
          3'd3: res = a | b;
          3'd4: res = a ^ b;
          3'd5: res = a << b[4:0];
          3'd6: res = a >> b[4:0];
          default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
      end
      2'd2: res = {22'd0, ins[9:0]};
      2'd3: e.ill = 1'b1;
      default: res = 32'd0;
    endcase
    if ((ins[19:18] == 2'd1 || ins[19:18] == 2'd2) && ins[17:13] != 0) mregs[ins[17:13]] = res;
    e.res = res;
    e.rd = ins[17:13];
    e.zero = (res == 32'd0);
    e.acc_edge = 0;
  endtask

  task automatic tick();
    exp_t e;
    bit   acc;
    @(negedge clk);
    if (held) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_result", ALU_Result, held_res);
      chk("hold_rd", out_rd, held_rd);
    end
    chk("retired_cnt", retired_cnt, model_ret);
    chk("illegal_cnt", illegal_cnt, model_ill);
    held = out_valid && !out_ready;
    held_res = ALU_Result;
    held_rd = out_rd;
    if (out_valid && exp_q.size() == 0) begin
      chk("spurious_valid", out_valid, 1'b0);
    end else if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      chk("result", ALU_Result, e.res);
      chk("out_rd", out_rd, e.rd);
      chk("out_zero", out_zero, e.zero);
      chk("out_ovf", out_ovf, e.ovf);
      chk("out_illegal", out_illegal, e.ill);
      if (chk_lat) chk("latency", cyc + 1, e.acc_edge + 2);
      obs_res.push_back(ALU_Result);
      obs_zero.push_back(out_zero);
      obs_ovf.push_back(out_ovf);
      obs_ill.push_back(out_illegal);
      if (model_ret < 65535) model_ret++;
      if (e.ill && model_ill < 65535) model_ill++;
    end
    acc = in_valid && in_ready;
    @(posedge clk);
    cyc++;
    #1;
    if (acc) begin
      model_exec(instruccion, e);
      e.acc_edge = cyc;
      exp_q.push_back(e);
      acc_flag = 1'b1;
    end
    if (rnd_rdy) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send(input logic [19:0] ins);
    in_valid = 1'b1;
    instruccion = ins;
    acc_flag = 1'b0;
    for (int k = 0; k < 50 && !acc_flag; k++) tick();
    chk("send_accepted", acc_flag, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clr_obs();
    obs_res.delete();
    obs_zero.delete();
    obs_ovf.delete();
    obs_ill.delete();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    exp_q.delete();
    model_ret = 0;
    model_ill = 0;
    held = 1'b0;
  endtask

  initial begin
    logic [19:0] ins;
    int          ret_base;
    rst = 1'b1;
    in_valid = 1'b0;
    instruccion = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    cyc += 2;
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", ALU_Result, 32'd0);
    chk("rst_illegal", out_illegal, 1'b0);
    chk("rst_retired", retired_cnt, 16'd0);
    chk("rst_illegal_cnt", illegal_cnt, 16'd0);

    // LOADI r2=7, LOADI r3=5
    clr_obs();
    send(mk(2, 2, 0, 0, 7));
    send(mk(2, 3, 0, 0, 5));
    drain();
    chk("loadi_r2", obs_res[0], 32'd7);
    chk("loadi_r3", obs_res[1], 32'd5);

    // Back-to-back dependent adds
    clr_obs();
    send(mk(1, 4, 0, 2, 3));
    send(mk(1, 5, 0, 4, 4));
    drain();
    chk("add_r4", obs_res[0], 32'd12);
    chk("add_r5_dep", obs_res[1], 32'd24);

    clr_obs();
    send(mk(1, 6, 1, 3, 2));
    send(mk(1, 7, 2, 2, 3));
    send(mk(1, 8, 1, 2, 2));
    drain();
    chk("sub_neg", obs_res[0], 32'hFFFF_FFFE);
    chk("sub_neg_zero", obs_zero[0], 1'b0);
    chk("sub_neg_ovf", obs_ovf[0], 1'b0);
    chk("and_r7", obs_res[1], 32'd5);
    chk("sub_zero_res", obs_res[2], 32'd0);
    chk("sub_zero_flag", obs_zero[2], 1'b1);

    clr_obs();
    send(mk(2, 9, 0, 0, 1));
    send(mk(2, 10, 0, 0, 30));
    send(mk(1, 11, 5, 9, 10));
    send(mk(1, 12, 0, 11, 11));
    drain();
    chk("sll_r11", obs_res[2], 32'h4000_0000);
    chk("add_ovf_res", obs_res[3], 32'h8000_0000);
    chk("add_ovf_flag", obs_ovf[3], 1'b1);

    // Back-pressure: stall the consumer while a 4-instruction stream arrives
    clr_obs();
    ret_base = model_ret;
    chk_lat = 1'b0;
    out_ready = 1'b0;
    send(mk(2, 20, 0, 1, 2));
    send(mk(1, 21, 4, 20, 3));
    in_valid = 1'b1;
    instruccion = mk(1, 22, 3, 21, 2);
    acc_flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_in_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    send(mk(1, 22, 3, 21, 2));
    send(mk(1, 23, 7, 3, 20));
    drain();
    chk("bp_count", obs_res.size(), 4);
    chk("bp_retired", retired_cnt, ret_base + 4);
    chk_lat = 1'b1;

    // Illegal opcode, LOADI to r0, then read r0
    clr_obs();
    send(mk(3, 1, 0, 0, 0));
    send(mk(2, 0, 0, 0, 9));
    send(mk(1, 13, 0, 0, 0));
    drain();
    chk("ill_flag", obs_ill[0], 1'b1);
    chk("ill_cnt", illegal_cnt, 16'd1);
    chk("loadi_r0_not_ill", obs_ill[1], 1'b0);
    chk("r0_reads_zero", obs_res[2], 32'd0);

    // Reset mid-stream
    send(mk(2, 14, 0, 10, 21));
    drain();
    send(mk(1, 15, 0, 14, 14));
    send(mk(1, 16, 3, 14, 2));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_retired", retired_cnt, 16'd0);
    chk("mid_rst_illegal", illegal_cnt, 16'd0);
    rst = 1'b0;
    model_reset();
    clr_obs();
    send(mk(1, 17, 0, 14, 0));
    drain();
    chk("reg_cleared", obs_res[0], 32'd0);

    // Randomised stream with a stuttering consumer
    chk_lat = 1'b0;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      ins = {$urandom_range(0, 3) == 0 ? 2'd2 : 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 7) == 0) ins[9:5] = 5'($urandom_range(0, 31));
      send(ins);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
